vls_sequencer: RTL and testbench

//  Expands one vector load/store (LW_V/SW_V) into LANES scalar element accesses for the data SRAM.

---
 rtl/isa_pkg.sv | 23 ++
 rtl/vls_elem_ctr.sv | 37 +++
 rtl/vls_sequencer.sv | 150 +++++++++++++++
 tb/tb_vls_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA constants for the vector load/store sequencer: opcodes, lane count,
// element-instruction field offsets and the sequencer state encoding.
package isa_pkg;

  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_LW_V = 6'h33;
  localparam logic [5:0] OP_SW_V = 6'h3B;

  localparam int unsigned LANES = 8;

  localparam int unsigned OPC_LSB   = 26;
  localparam int unsigned VEC_BIT   = 30;
  localparam int unsigned SHAMT_MSB = 10;
  localparam int unsigned SHAMT_LSB = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } vls_state_e;

endpackage

// File: rtl/vls_elem_ctr.sv
// Element counter for a vector expansion: latches the clamped length, steps the
// lane index, and flags the final element.
module vls_elem_ctr #(
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [IDX_W:0]   len_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o
);

  logic [IDX_W:0]   len_q;
  logic [IDX_W-1:0] idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
      idx_q <= '0;
    end else if (load_i) begin
      len_q <= len_i;
      idx_q <= '0;
    end else if (clr_i) begin
      idx_q <= '0;
    end else if (inc_i) begin
      idx_q <= idx_q + IDX_W'(1);
    end
  end

  // A zero length never reaches BUSY, so the wrapped len-1 compare is harmless.
  assign last_o = ({1'b0, idx_q} == (len_q - (IDX_W+1)'(1)));
  assign idx_o  = idx_q;

endmodule

// File: rtl/vls_sequencer.sv
// Expands LW_V/SW_V into per-lane scalar LW/SW element accesses, stalling IF while
// elements issue; scalar instructions pass through with one cycle of latency.
module vls_sequencer import isa_pkg::*; #(
  parameter int unsigned LANES   = isa_pkg::LANES,
  parameter int unsigned IDX_W   = 3,
  parameter logic [5:0]  OP_LW_V = isa_pkg::OP_LW_V,
  parameter logic [5:0]  OP_SW_V = isa_pkg::OP_SW_V
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instn_valid,
  input  logic [31:0]      instn_in,
  input  logic [31:0]      vlen,
  input  logic             flush,
  input  logic             mem_ack,
  output logic [31:0]      instn_out,
  output logic             elem_valid,
  output logic [IDX_W-1:0] elem_idx,
  output logic             mem_req,
  output logic             stall_if,
  output logic             vdone
);

  vls_state_e       state_q;
  logic [31:0]      instn_q;
  logic [31:0]      instn_out_q;
  logic             elem_valid_q;
  logic             mem_req_q;
  logic             vdone_q;

  logic [5:0]       opcode;
  logic             is_vec;
  logic             detect;
  logic [IDX_W:0]   vlen_lo;
  logic [IDX_W:0]   len_d;
  logic [IDX_W-1:0] idx_cur;
  logic [IDX_W-1:0] idx_inc;
  logic             idx_last;
  logic             ctr_inc;
  logic             ctr_clr;
  logic             unused_vlen_hi;

  function automatic logic [31:0] elem_instn(input logic [31:0]      base,
                                             input logic [IDX_W-1:0] idx);
    logic [31:0] r;
    r                      = base;
    r[VEC_BIT]             = 1'b0;
    r[SHAMT_MSB:SHAMT_LSB] = 5'(idx);
    return r;
  endfunction

  assign opcode  = instn_in[31:OPC_LSB];
  assign is_vec  = (opcode == OP_LW_V) || (opcode == OP_SW_V);
  assign detect  = (state_q == IDLE) && instn_valid && is_vec && !flush;
  assign vlen_lo = vlen[IDX_W:0];
  assign len_d   = (vlen_lo > (IDX_W+1)'(LANES)) ? (IDX_W+1)'(LANES) : vlen_lo;
  assign idx_inc = idx_cur + IDX_W'(1);
  assign unused_vlen_hi = ^vlen[31:IDX_W+1];

  assign ctr_inc = (state_q == BUSY) && mem_ack && !flush && !idx_last;
  assign ctr_clr = ((state_q == BUSY) && flush) || (state_q == DONE);

  vls_elem_ctr #(.IDX_W(IDX_W)) u_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (detect),
    .len_i  (len_d),
    .inc_i  (ctr_inc),
    .clr_i  (ctr_clr),
    .idx_o  (idx_cur),
    .last_o (idx_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      instn_q      <= '0;
      instn_out_q  <= '0;
      elem_valid_q <= 1'b0;
      mem_req_q    <= 1'b0;
      vdone_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          vdone_q <= 1'b0;
          if (detect) begin
            instn_q <= instn_in;
            if (len_d == '0) begin
              state_q      <= DONE;
              instn_out_q  <= '0;
              elem_valid_q <= 1'b0;
              mem_req_q    <= 1'b0;
              vdone_q      <= 1'b1;
            end else begin
              state_q      <= BUSY;
              instn_out_q  <= elem_instn(instn_in, '0);
              elem_valid_q <= 1'b1;
              mem_req_q    <= 1'b1;
            end
          end else begin
            instn_out_q  <= instn_in;
            elem_valid_q <= 1'b0;
            mem_req_q    <= 1'b0;
          end
        end
        BUSY: begin
          // Flush wins over completion: an ack on the flush cycle is taken but no vdone follows.
          if (flush) begin
            state_q      <= IDLE;
            instn_out_q  <= '0;
            elem_valid_q <= 1'b0;
            mem_req_q    <= 1'b0;
          end else if (mem_ack) begin
            if (idx_last) begin
              state_q      <= DONE;
              instn_out_q  <= '0;
              elem_valid_q <= 1'b0;
              mem_req_q    <= 1'b0;
              vdone_q      <= 1'b1;
            end else begin
              instn_out_q <= elem_instn(instn_q, idx_inc);
            end
          end
        end
        DONE: begin
          state_q      <= IDLE;
          instn_out_q  <= '0;
          elem_valid_q <= 1'b0;
          mem_req_q    <= 1'b0;
          vdone_q      <= 1'b0;
        end
        default: begin
          state_q      <= IDLE;
          instn_out_q  <= '0;
          elem_valid_q <= 1'b0;
          mem_req_q    <= 1'b0;
          vdone_q      <= 1'b0;
        end
      endcase
    end
  end

  assign instn_out  = instn_out_q;
  assign elem_valid = elem_valid_q;
  assign elem_idx   = idx_cur;
  assign mem_req    = mem_req_q;
  assign vdone      = vdone_q;
  assign stall_if   = detect || (state_q == BUSY);

endmodule

// File: tb/tb_vls_sequencer.sv
// Directed bench for vls_sequencer: a per-cycle vector table plus hand-written
// multi-cycle sequences (full expansion, ack wait states, flush, async reset).
module tb_vls_sequencer;

  localparam logic [31:0] ADD   = 32'h01095020;
  localparam logic [31:0] LWV   = 32'hCC220010;
  localparam logic [31:0] LWV_E = 32'h8C220010;
  localparam logic [31:0] SWV   = 32'hEC640004;
  localparam logic [31:0] SWV_E = 32'hAC640004;

  logic        clk;
  logic        rst_n;
  logic        instn_valid;
  logic [31:0] instn_in;
  logic [31:0] vlen;
  logic        flush;
  logic        mem_ack;
  logic [31:0] instn_out;
  logic        elem_valid;
  logic [2:0]  elem_idx;
  logic        mem_req;
  logic        stall_if;
  logic        vdone;

  int tests;
  int fails;

  typedef struct {
    logic        valid;
    logic [31:0] instn;
    logic [31:0] vl;
    logic        fl;
    logic        ack;
    logic [31:0] e_out;
    logic        e_ev;
    logic [2:0]  e_idx;
    logic        e_req;
    logic        e_stall;
    logic        e_vd;
  } vec_t;

  vec_t tbl[13];

  vls_sequencer #(.LANES(8), .IDX_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instn_valid (instn_valid),
    .instn_in    (instn_in),
    .vlen        (vlen),
    .flush       (flush),
    .mem_ack     (mem_ack),
    .instn_out   (instn_out),
    .elem_valid  (elem_valid),
    .elem_idx    (elem_idx),
    .mem_req     (mem_req),
    .stall_if    (stall_if),
    .vdone       (vdone)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_out, input logic e_ev,
                         input logic [2:0] e_idx, input logic e_req, input logic e_stall,
                         input logic e_vd);
    chk({tag, ".instn_out"}, instn_out, e_out);
    chk({tag, ".elem_valid"}, 32'(elem_valid), 32'(e_ev));
    chk({tag, ".elem_idx"}, 32'(elem_idx), 32'(e_idx));
    chk({tag, ".mem_req"}, 32'(mem_req), 32'(e_req));
    chk({tag, ".stall_if"}, 32'(stall_if), 32'(e_stall));
    chk({tag, ".vdone"}, 32'(vdone), 32'(e_vd));
  endtask

  // Inputs change on the falling edge; outputs are sampled 2ns later, well before the rising edge.
  task automatic drive(input logic v, input logic [31:0] in, input logic [31:0] vl,
                       input logic fl, input logic ak);
    @(negedge clk);
    instn_valid = v;
    instn_in    = in;
    vlen        = vl;
    flush       = fl;
    mem_ack     = ak;
    #2;
  endtask

  initial begin
    int acks;
    tests = 0;
    fails = 0;

    tbl[0]  = '{1'b1, ADD, 32'd2, 1'b0, 1'b0, 32'h0,         1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, LWV, 32'd2, 1'b0, 1'b1, ADD,           1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, LWV, 32'd2, 1'b0, 1'b1, LWV_E,         1'b1, 3'd0, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, LWV, 32'd2, 1'b0, 1'b1, 32'h8C220050,  1'b1, 3'd1, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, LWV, 32'd2, 1'b0, 1'b1, 32'h0,         1'b0, 3'd1, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, ADD, 32'd2, 1'b0, 1'b0, 32'h0,         1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 32'h0, 32'd2, 1'b0, 1'b0, ADD,         1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, LWV, 32'd2, 1'b0, 1'b0, 32'h0,         1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, LWV, 32'd2, 1'b1, 1'b0, LWV,           1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 32'h0, 32'd2, 1'b0, 1'b0, LWV,         1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, LWV, 32'd0, 1'b0, 1'b0, 32'h0,         1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 32'h0,       1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 32'h0,       1'b0, 3'd0, 1'b0, 1'b0, 1'b0};

    rst_n       = 1'b0;
    instn_valid = 1'b0;
    instn_in    = '0;
    vlen        = '0;
    flush       = 1'b0;
    mem_ack     = 1'b0;
    #3;
    chk_all("reset", 32'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].valid, tbl[i].instn, tbl[i].vl, tbl[i].fl, tbl[i].ack);
      chk_all($sformatf("tbl%0d", i), tbl[i].e_out, tbl[i].e_ev, tbl[i].e_idx,
              tbl[i].e_req, tbl[i].e_stall, tbl[i].e_vd);
    end

    // Full LW_V expansion; vlen=12 must clamp to 8 lanes, and vlen edits mid-BUSY are ignored.
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, LWV, (k == 0) ? 32'd8 : 32'd12, 1'b0, 1'b1);
      chk($sformatf("A%0d.det_stall", k), 32'(stall_if), 32'd1);
      chk($sformatf("A%0d.det_req", k), 32'(mem_req), 32'd0);
      for (int i = 0; i < 8; i++) begin
        drive(1'b1, LWV, 32'd0, 1'b0, 1'b1);
        chk_all($sformatf("A%0d.e%0d", k, i), LWV_E | (32'(i) << 6), 1'b1, 3'(i), 1'b1, 1'b1, 1'b0);
      end
      drive(1'b0, 32'h0, 32'd0, 1'b0, 1'b1);
      chk_all($sformatf("A%0d.done", k), 32'h0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 32'h0, 32'd0, 1'b0, 1'b0);
      chk($sformatf("A%0d.vdone_pulse", k), 32'(vdone), 32'd0);
    end

    // SW_V, vlen=3, two wait cycles before each ack.
    drive(1'b1, SWV, 32'd3, 1'b0, 1'b0);
    chk("B.det_stall", 32'(stall_if), 32'd1);
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < 3; w++) begin
        drive(1'b1, SWV, 32'd3, 1'b0, (w == 2));
        chk_all($sformatf("B.e%0d.w%0d", i, w), SWV_E | (32'(i) << 6), 1'b1, 3'(i), 1'b1, 1'b1, 1'b0);
        if (mem_req && mem_ack) acks++;
      end
    end
    drive(1'b0, 32'h0, 32'd3, 1'b0, 1'b0);
    chk("B.vdone", 32'(vdone), 32'd1);
    chk("B.acks", 32'(acks), 32'd3);

    // Flush together with the ack of element 2.
    drive(1'b1, LWV, 32'd8, 1'b0, 1'b1);
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, LWV, 32'd8, (i == 2), 1'b1);
      chk($sformatf("C.idx%0d", i), 32'(elem_idx), 32'(i));
      chk($sformatf("C.req%0d", i), 32'(mem_req), 32'd1);
      if (mem_req && mem_ack) acks++;
    end
    drive(1'b1, ADD, 32'd8, 1'b0, 1'b1);
    chk_all("C.after_flush", 32'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    if (mem_req && mem_ack) acks++;
    drive(1'b0, 32'h0, 32'd8, 1'b0, 1'b0);
    chk_all("C.passthru", ADD, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("C.acks", 32'(acks), 32'd3);

    // Asynchronous reset while element 4 is outstanding.
    drive(1'b1, LWV, 32'd8, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, LWV, 32'd8, 1'b0, 1'b1);
      chk($sformatf("D.idx%0d", i), 32'(elem_idx), 32'(i));
    end
    #1;
    rst_n       = 1'b0;
    instn_valid = 1'b0;
    #1;
    chk_all("D.async_rst", 32'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, LWV, 32'd8, 1'b0, 1'b0);
    chk("D.redetect_stall", 32'(stall_if), 32'd1);
    drive(1'b1, LWV, 32'd8, 1'b0, 1'b0);
    chk_all("D.restart", LWV_E, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'd8, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'd8, 1'b0, 1'b0);
    chk("D.flushed_idle", 32'(mem_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
